// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and limits for the BCD time-of-day counter
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HOUR = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

  localparam logic [7:0] MAX_SEC  = 8'h59;
  localparam logic [7:0] MAX_MIN  = 8'h59;
  localparam logic [7:0] MAX_HOUR = 8'h23;

  // Both digits of a packed BCD pair are within 0..9
  function automatic logic bcd_legal(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/clock_time_counter_if.sv
// rtl/clock_time_counter_if.sv - control inputs and display outputs of the time counter
interface clock_time_counter_if;
  import clock_pkg::*;

  logic       tick_1hz;
  logic       set_en;
  logic [1:0] sel;
  logic       inc;
  bcd_t       CH, CL, MH, ML, SH, SL;
  logic       day_pulse;
  logic       chime;

  modport master (
    output tick_1hz, set_en, sel, inc,
    input  CH, CL, MH, ML, SH, SL, day_pulse, chime
  );

  modport slave (
    input  tick_1hz, set_en, sel, inc,
    output CH, CL, MH, ML, SH, SL, day_pulse, chime
  );

endinterface

// File: rtl/clock_time_counter_bcd_mod_counter.sv
// rtl/clock_time_counter_bcd_mod_counter.sv - two-digit BCD modulo counter, 00..MAX
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX  = 8'h59,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_en,
  input  logic clr,
  output bcd_t hi,
  output bcd_t lo,
  output logic carry
);

  logic [7:0] value;
  logic [7:0] value_nxt;

  assign hi    = value[7:4];
  assign lo    = value[3:0];
  // Carry only from the legal top value, so a corrupt field never ripples
  assign carry = inc_en && (value == MAX);

  // Next value: clear, or increment with wrap; anything illegal or out of range wraps to 00
  always_comb begin
    value_nxt = value;
    if (clr) begin
      value_nxt = 8'h00;
    end else if (inc_en) begin
      if (!bcd_legal(value) || (value >= MAX)) begin
        value_nxt = 8'h00;
      end else if (value[3:0] == 4'd9) begin
        value_nxt = {value[7:4] + 4'd1, 4'd0};
      end else begin
        value_nxt = {value[7:4], value[3:0] + 4'd1};
      end
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT;
    end else begin
      value <= value_nxt;
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - hh:mm:ss BCD counter with set mode; optional hourly chime via CHIME_EN
module clock_time_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] INIT_H = 8'h00,
  parameter logic [7:0] INIT_M = 8'h00,
  parameter logic [7:0] INIT_S = 8'h00
) (
  input logic                  clk,
  input logic                  rst_n,
  clock_time_counter_if.slave  bus
);

  logic run;
  logic adj;
  logic sec_inc, sec_clr, sec_carry;
  logic min_inc, min_carry;
  logic hour_inc, hour_carry;
  logic day_q;

  assign run = !bus.set_en;
  assign adj = bus.set_en && bus.inc;

  // In run mode the carries chain all three fields in one cycle; in set mode
  // each field is touched only by its own inc, so no carry leaks between them.
  assign sec_inc  = run && bus.tick_1hz;
  assign sec_clr  = adj && (bus.sel == SEL_SEC);
  assign min_inc  = run ? sec_carry : (adj && (bus.sel == SEL_MIN));
  assign hour_inc = run ? min_carry : (adj && (bus.sel == SEL_HOUR));

  bcd_mod_counter #(.MAX(MAX_SEC), .INIT(INIT_S)) u_sec (
    .clk(clk), .rst_n(rst_n), .inc_en(sec_inc), .clr(sec_clr),
    .hi(bus.SH), .lo(bus.SL), .carry(sec_carry)
  );

  bcd_mod_counter #(.MAX(MAX_MIN), .INIT(INIT_M)) u_min (
    .clk(clk), .rst_n(rst_n), .inc_en(min_inc), .clr(1'b0),
    .hi(bus.MH), .lo(bus.ML), .carry(min_carry)
  );

  bcd_mod_counter #(.MAX(MAX_HOUR), .INIT(INIT_H)) u_hour (
    .clk(clk), .rst_n(rst_n), .inc_en(hour_inc), .clr(1'b0),
    .hi(bus.CH), .lo(bus.CL), .carry(hour_carry)
  );

  // Day pulse lands on the same cycle the display shows 00:00:00; set-mode hour wrap excluded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q <= 1'b0;
    end else begin
      day_q <= run && hour_carry;
    end
  end

  assign bus.day_pulse = day_q;

`ifdef CHIME_EN
  logic [7:0] sec_now;
  logic       min_is_59;
  logic       sec_pre;
  logic       sec_at;
  logic       chime_q;

  assign sec_now   = {bus.SH, bus.SL};
  assign min_is_59 = ({bus.MH, bus.ML} == 8'h59);
  // Seconds one step before a chime second (ticking into it) and chime seconds themselves
  assign sec_pre   = (sec_now == 8'h50) || (sec_now == 8'h52) || (sec_now == 8'h54) ||
                     (sec_now == 8'h56) || (sec_now == 8'h58);
  assign sec_at    = (sec_now == 8'h51) || (sec_now == 8'h53) || (sec_now == 8'h55) ||
                     (sec_now == 8'h57) || (sec_now == 8'h59);

  // Chime predicted from the value the digits take this edge, so it stays aligned with them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chime_q <= 1'b0;
    end else begin
      chime_q <= run && min_is_59 && (bus.tick_1hz ? sec_pre : sec_at);
    end
  end

  assign bus.chime = chime_q;
`else
  assign bus.chime = 1'b0;
`endif

endmodule
